// File: rtl/small_lang_mem_pkg.sv
// Shared types and sizing for the load/store path: op and FSM encodings, word/address widths.
package small_lang_mem_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 16;
   localparam int MEM_WORDS = 512;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_STORE = 2'd1,
      OP_SWAP  = 2'd2,
      OP_ADD   = 2'd3
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Memory-access stage with atomic SWAP/ADD; response 1 (error), 2 (LOAD/STORE) or 3 (SWAP/ADD) cycles after handshake.
// One request in flight: req_ready only in IDLE; responses are a one-cycle strobe with no backpressure.
module load_store_unit
   import small_lang_mem_pkg::*;
#(
   parameter int MEM_WORDS = small_lang_mem_pkg::MEM_WORDS,
   parameter int DATA_W    = small_lang_mem_pkg::DATA_W,
   parameter int ADDR_W    = small_lang_mem_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic              mem_ctl_write_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef struct packed {
      mem_op_t           op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } lsu_req_t;

   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS);

   lsu_state_t        state;
   lsu_req_t          req_q;
   logic [DATA_W-1:0] rdata_q;
   logic              out_of_range;
   logic              req_hs;

   assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
   assign req_hs       = req_valid && req_ready;

   // Gated by rst so a reset landing in WRITE never reaches the falling-edge memory.
   assign mem_ctl_write_enable = (state == ST_WRITE) && !rst;
   assign req_ready            = (state == ST_IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         rdata_q    <= '0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_hs) begin
                  req_q <= '{op: mem_op_t'(req_op), addr: req_addr, wdata: req_wdata};
                  if (out_of_range) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     mem_addr   <= req_addr;
                     resp_error <= 1'b0;
                     if (mem_op_t'(req_op) == OP_STORE) begin
                        mem_wdata <= req_wdata;
                        state     <= ST_WRITE;
                     end else begin
                        state <= ST_READ;
                     end
                  end
               end
            end
            ST_READ: begin
               rdata_q <= mem_rdata;
               if (req_q.op == OP_LOAD) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= mem_rdata;
               end else begin
                  state <= ST_WRITE;
                  // Sum formed from the word arriving now, i.e. the same value landing in rdata_q.
                  if (req_q.op == OP_ADD) begin
                     mem_wdata <= mem_rdata + req_q.wdata;
                  end else begin
                     mem_wdata <= req_q.wdata;
                  end
               end
            end
            ST_WRITE: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= (req_q.op == OP_STORE) ? '0 : rdata_q;
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               resp_error <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a falling-edge 512-word memory model.
module tb_load_store_unit;
   import small_lang_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [15:0] req_addr = 16'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_error;
   logic        mem_ctl_write_enable;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   logic [15:0] mem [0:511] = '{default: 16'h0};
   int          we_total = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(512), .DATA_W(16), .ADDR_W(16)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_op               (req_op),
      .req_addr             (req_addr),
      .req_wdata            (req_wdata),
      .resp_valid           (resp_valid),
      .resp_rdata           (resp_rdata),
      .resp_error           (resp_error),
      .mem_ctl_write_enable (mem_ctl_write_enable),
      .mem_addr             (mem_addr),
      .mem_wdata            (mem_wdata),
      .mem_rdata            (mem_rdata)
   );

   // Memory model: samples on the falling edge, returns 0 during write cycles.
   always @(negedge clk) begin
      if (mem_ctl_write_enable) begin
         if (mem_addr < 16'd512) mem[mem_addr[8:0]] <= mem_wdata;
         mem_rdata <= 16'h0;
      end else begin
         mem_rdata <= (mem_addr < 16'd512) ? mem[mem_addr[8:0]] : 16'h0;
      end
   end

   always @(posedge clk) if (mem_ctl_write_enable) we_total <= we_total + 1;

   // Issue one request and wait for its response; lat counts edges from the handshake edge (inclusive).
   task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rdata, output logic err, output int we_cnt);
      int guard;
      req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; we_cnt = 0; rdata = 'x; err = 1'bx;
      while (!resp_valid && lat < 10) begin
         if (mem_ctl_write_enable) we_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (resp_valid) begin rdata = resp_rdata; err = resp_error; end
      else lat = 99;
   endtask

   task automatic test_reset();
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset: got %b expected 0", req_ready); end
      n_vec++;
      if (mem_ctl_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_we_in_reset: got %b expected 0", mem_ctl_write_enable); end
      n_vec++;
      rst = 1'b0; #1;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
      n_vec++;
      if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
      n_vec++;
      if (resp_error !== 1'b0) begin n_err++; $display("FAIL rst_resp_error: got %b expected 0", resp_error); end
      n_vec++;
      if (resp_rdata !== 16'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h expected 0000", resp_rdata); end
      n_vec++;
      if (mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
      n_vec++;
      if (mem_wdata !== 16'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); end
      n_vec++;
   endtask

   task automatic test_store_load();
      int lat, wc; logic [15:0] rd; logic er;
      do_req(OP_STORE, 16'd5, 16'h1234, lat, rd, er, wc);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL store_latency: got %0d expected 2", lat); end
      n_vec++; if (rd !== 16'h0) begin n_err++; $display("FAIL store_rdata: got %h expected 0000", rd); end
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL store_error: got %b expected 0", er); end
      n_vec++; if (wc != 1) begin n_err++; $display("FAIL store_we_cycles: got %0d expected 1", wc); end
      @(posedge clk); #1;
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL store_resp_pulse: got %b expected 0", resp_valid); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL store_ready_after: got %b expected 1", req_ready); end
      n_vec++; if (mem[5] !== 16'h1234) begin n_err++; $display("FAIL store_mem5: got %h expected 1234", mem[5]); end
      do_req(OP_LOAD, 16'd5, 16'h0, lat, rd, er, wc);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL load_latency: got %0d expected 2", lat); end
      n_vec++; if (rd !== 16'h1234) begin n_err++; $display("FAIL load_rdata: got %h expected 1234", rd); end
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL load_error: got %b expected 0", er); end
      n_vec++; if (wc != 0) begin n_err++; $display("FAIL load_we_cycles: got %0d expected 0", wc); end
      @(posedge clk); #1;
   endtask

   task automatic test_swap();
      int lat, wc; logic [15:0] rd; logic er;
      do_req(OP_STORE, 16'd7, 16'h0001, lat, rd, er, wc);
      @(posedge clk); #1;
      do_req(OP_SWAP, 16'd7, 16'hBEEF, lat, rd, er, wc);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL swap_latency: got %0d expected 3", lat); end
      n_vec++; if (rd !== 16'h0001) begin n_err++; $display("FAIL swap_rdata: got %h expected 0001", rd); end
      n_vec++; if (wc != 1) begin n_err++; $display("FAIL swap_we_cycles: got %0d expected 1", wc); end
      @(posedge clk); #1;
      do_req(OP_LOAD, 16'd7, 16'h0, lat, rd, er, wc);
      n_vec++; if (rd !== 16'hBEEF) begin n_err++; $display("FAIL swap_readback: got %h expected beef", rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_add_wrap();
      int lat, wc; logic [15:0] rd; logic er;
      do_req(OP_STORE, 16'd3, 16'hFFFF, lat, rd, er, wc);
      @(posedge clk); #1;
      do_req(OP_ADD, 16'd3, 16'h0002, lat, rd, er, wc);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL add_latency: got %0d expected 3", lat); end
      n_vec++; if (rd !== 16'hFFFF) begin n_err++; $display("FAIL add_rdata: got %h expected ffff", rd); end
      n_vec++; if (mem[3] !== 16'h0001) begin n_err++; $display("FAIL add_mem3: got %h expected 0001", mem[3]); end
      @(posedge clk); #1;
      do_req(OP_LOAD, 16'd3, 16'h0, lat, rd, er, wc);
      n_vec++; if (rd !== 16'h0001) begin n_err++; $display("FAIL add_readback: got %h expected 0001", rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_range();
      int lat, wc, we0; logic [15:0] rd; logic er;
      we0 = we_total;
      do_req(OP_LOAD, 16'd512, 16'h0, lat, rd, er, wc);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL oor_load_latency: got %0d expected 1", lat); end
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_load_error: got %b expected 1", er); end
      n_vec++; if (rd !== 16'h0) begin n_err++; $display("FAIL oor_load_rdata: got %h expected 0000", rd); end
      @(posedge clk); #1;
      do_req(OP_STORE, 16'hFFFF, 16'hAAAA, lat, rd, er, wc);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL oor_store_latency: got %0d expected 1", lat); end
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_store_error: got %b expected 1", er); end
      n_vec++; if (rd !== 16'h0) begin n_err++; $display("FAIL oor_store_rdata: got %h expected 0000", rd); end
      @(posedge clk); #1;
      n_vec++; if (we_total != we0) begin n_err++; $display("FAIL oor_no_write: got %0d writes expected 0", we_total - we0); end
      do_req(OP_STORE, 16'd511, 16'h7777, lat, rd, er, wc);
      @(posedge clk); #1;
      do_req(OP_LOAD, 16'd511, 16'h0, lat, rd, er, wc);
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL top_addr_error: got %b expected 0", er); end
      n_vec++; if (rd !== 16'h7777) begin n_err++; $display("FAIL top_addr_rdata: got %h expected 7777", rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_write();
      int lat, wc, we0, guard, pulses; logic [15:0] rd; logic er;
      req_op = OP_STORE; req_addr = 16'd9; req_wdata = 16'h5555; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Now in the WRITE cycle, before the falling edge.
      we0 = we_total;
      rst = 1'b1; #1;
      n_vec++; if (mem_ctl_write_enable !== 1'b0) begin n_err++; $display("FAIL rstw_we: got %b expected 0", mem_ctl_write_enable); end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_ready: got %b expected 1", req_ready); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid) pulses++;
         @(posedge clk); #1;
      end
      n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rstw_no_resp: got %0d expected 0", pulses); end
      n_vec++; if (we_total != we0) begin n_err++; $display("FAIL rstw_no_write: got %0d writes expected 0", we_total - we0); end
      n_vec++; if (mem[9] !== 16'h0) begin n_err++; $display("FAIL rstw_mem9: got %h expected 0000", mem[9]); end
      do_req(OP_LOAD, 16'd9, 16'h0, lat, rd, er, wc);
      n_vec++; if (rd !== 16'h0) begin n_err++; $display("FAIL rstw_readback: got %h expected 0000", rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat, wc, n_acc, n_resp; logic [15:0] rd; logic er; logic busy, hs;
      logic [15:0] addrs [3];
      logic [15:0] exp_d [3];
      addrs = '{16'd20, 16'd21, 16'd22};
      exp_d = '{16'hA001, 16'hA002, 16'hA003};
      for (int i = 0; i < 3; i++) begin
         do_req(OP_STORE, addrs[i], exp_d[i], lat, rd, er, wc);
         @(posedge clk); #1;
      end
      n_acc = 0; n_resp = 0; busy = 1'b0;
      req_op = OP_LOAD; req_addr = addrs[0]; req_wdata = 16'h0; req_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && n_resp < 3; cyc++) begin
         if (busy) begin
            n_vec++;
            if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_busy: got %b expected 0 (cycle %0d)", req_ready, cyc); end
         end
         if (resp_valid) begin
            n_vec++;
            if (resp_rdata !== exp_d[n_resp] || resp_error !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_resp%0d: got %h/%b expected %h/0", n_resp, resp_rdata, resp_error, exp_d[n_resp]);
            end
            n_resp++;
            busy = 1'b0;
         end
         hs = req_valid && req_ready;
         @(posedge clk); #1;
         if (hs) begin
            n_acc++;
            busy = 1'b1;
            if (n_acc < 3) req_addr = addrs[n_acc];
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      n_vec++; if (n_acc != 3) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 3", n_acc); end
      n_vec++; if (n_resp != 3) begin n_err++; $display("FAIL b2b_responses: got %0d expected 3", n_resp); end
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(posedge clk); #1;
      test_store_load();
      test_swap();
      test_add_wrap();
      test_range();
      test_reset_mid_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
